// File: rtl/column_pkg.sv
// Shared widths, defaults and types for the column encoder and its record FIFO.
package column_pkg;

    localparam int unsigned COL_W          = 10;
    localparam int unsigned HEIGHT_W       = 10;
    localparam int unsigned COLOR_W        = 15;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned GAP_W          = 4;
    localparam int unsigned NUM_COLS_DEF   = 640;
    localparam int unsigned MAX_HEIGHT_DEF = 480;
    localparam int unsigned START_BIT      = 15;

    // One raycast result as stored in the record FIFO (height already clamped)
    typedef struct packed {
        logic [COL_W-1:0]    idx;
        logic [HEIGHT_W-1:0] height;
        logic [COLOR_W-1:0]  color;
    } col_rec_t;

    typedef enum logic [2:0] {
        IDLE,
        W0,
        W1,
        W2,
        GAP
    } enc_state_t;

    // Saturate a wall height to the clamp value
    function automatic logic [HEIGHT_W-1:0] clamp_height(
        input logic [HEIGHT_W-1:0] h,
        input int unsigned         max_h
    );
        return (32'(h) > max_h) ? HEIGHT_W'(max_h) : h;
    endfunction

endpackage

// File: rtl/col_fifo.sv
// Synchronous record FIFO; flags are registered, head is a combinational read.
module col_fifo
    import column_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  logic     pop,
    input  col_rec_t wr_rec,
    output col_rec_t head_c,
    output logic     not_full,
    output logic     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    col_rec_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & not_full;
    assign pop_ok  = pop & ~empty;
    assign head_c  = mem[rd_ptr];

    // Occupancy after this edge; drives both flags so they are exact every cycle
    always_comb begin
        count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    // Pointers, count and flags; not_full held low through reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            not_full <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_nxt;
            not_full <= (count_nxt != CNT_W'(DEPTH));
            empty    <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/column_encoder.sv
// Buffers raycast column records and serializes each into a 3-word write burst.
module column_encoder
    import column_pkg::*;
#(
    parameter int unsigned NUM_COLS    = NUM_COLS_DEF,
    parameter int unsigned MAX_HEIGHT  = MAX_HEIGHT_DEF,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned WRITE_GAP   = 0,
    parameter int unsigned GATE_VBLANK = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                col_valid,
    output logic                col_ready,
    input  logic [COL_W-1:0]    col_idx,
    input  logic [HEIGHT_W-1:0] col_height,
    input  logic [COLOR_W-1:0]  col_color,
    input  logic                vblank,
    output logic [DATA_W-1:0]   writedata,
    output logic                write,
    output logic                chipselect,
    output logic                frame_done,
    output logic                err_col
);

    enc_state_t          state;
    enc_state_t          state_nxt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [GAP_W-1:0]    gap_nxt;
    col_rec_t            cur_rec;
    col_rec_t            rec_nxt;
    col_rec_t            head_c;
    col_rec_t            push_rec;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_not_full;
    logic                head_ok;
    logic                gate_open;
    logic                can_start;
    logic [DATA_W-1:0]   wd_d;
    logic                wr_d;
    logic                fd_d;

    assign col_ready = fifo_not_full;
    assign push      = col_valid & col_ready;
    assign head_ok   = (32'(head_c.idx) < NUM_COLS);
    assign gate_open = vblank | (GATE_VBLANK == 0);

    // Clamp on the way in so the FIFO only ever holds bus-ready heights
    always_comb begin
        push_rec        = '0;
        push_rec.idx    = col_idx;
        push_rec.height = clamp_height(col_height, MAX_HEIGHT);
        push_rec.color  = col_color;
    end

    col_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .wr_rec   (push_rec),
        .head_c   (head_c),
        .not_full (fifo_not_full),
        .empty    (fifo_empty)
    );

    // Next state: burst sequencing, gap counting and start/discard decisions
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        pop       = 1'b0;
        can_start = 1'b0;
        case (state)
            IDLE: can_start = 1'b1;
            W0:   state_nxt = W1;
            W1:   state_nxt = W2;
            W2: begin
                if (WRITE_GAP > 0) begin
                    state_nxt = GAP;
                    gap_nxt   = '0;
                end else begin
                    can_start = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(WRITE_GAP - 1)) begin
                    can_start = 1'b1;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Last cycle of a burst or gap evaluates the next start directly
        if (can_start) begin
            state_nxt = IDLE;
            if (!fifo_empty) begin
                if (!head_ok) begin
                    pop = 1'b1;
                end else if (gate_open) begin
                    pop       = 1'b1;
                    state_nxt = W0;
                end
            end
        end
    end

    // Output decode for the state being entered, registered below
    always_comb begin
        wd_d    = '0;
        wr_d    = 1'b0;
        fd_d    = 1'b0;
        rec_nxt = pop ? head_c : cur_rec;
        case (state_nxt)
            W0: begin
                wd_d            = DATA_W'(rec_nxt.idx);
                wd_d[START_BIT] = 1'b1;
                wr_d            = 1'b1;
            end
            W1: begin
                wd_d = DATA_W'(rec_nxt.height);
                wr_d = 1'b1;
            end
            W2: begin
                wd_d = {1'b0, rec_nxt.color};
                wr_d = 1'b1;
                fd_d = (32'(rec_nxt.idx) == NUM_COLS - 1);
            end
            default: ;
        endcase
    end

    // State, current record and registered bus outputs; reset drops any burst
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            cur_rec    <= '0;
            writedata  <= '0;
            write      <= 1'b0;
            chipselect <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= gap_nxt;
            cur_rec    <= rec_nxt;
            writedata  <= wd_d;
            write      <= wr_d;
            chipselect <= wr_d;
            frame_done <= fd_d;
        end
    end

    // Sticky flag for out-of-range column indices seen at acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_col <= 1'b0;
        end else if (push && (32'(col_idx) >= NUM_COLS)) begin
            err_col <= 1'b1;
        end
    end

endmodule

// File: tb/tb_column_encoder.sv
// Bench for column_encoder: queue-based word model plus directed literal checks.
module tb_column_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_a, valid_b;
    logic        rdy_a, rdy_b;
    logic [9:0]  col_idx;
    logic [9:0]  col_height;
    logic [14:0] col_color;
    logic        vblank;
    logic [15:0] wd_a, wd_b;
    logic        wr_a, wr_b, cs_a, cs_b, fd_a, fd_b, err_a, err_b;

    always #5 clk = ~clk;

    column_encoder u_dut (
        .clk(clk), .reset_n(reset_n), .col_valid(valid_a), .col_ready(rdy_a),
        .col_idx(col_idx), .col_height(col_height), .col_color(col_color),
        .vblank(vblank), .writedata(wd_a), .write(wr_a), .chipselect(cs_a),
        .frame_done(fd_a), .err_col(err_a)
    );

    column_encoder #(.WRITE_GAP(2)) u_gap (
        .clk(clk), .reset_n(reset_n), .col_valid(valid_b), .col_ready(rdy_b),
        .col_idx(col_idx), .col_height(col_height), .col_color(col_color),
        .vblank(vblank), .writedata(wd_b), .write(wr_b), .chipselect(cs_b),
        .frame_done(fd_b), .err_col(err_b)
    );

    typedef struct packed {
        logic [15:0] wd;
        logic        fd;
        logic [1:0]  pos;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   exp_err_a = 0, exp_err_b = 0;
    bit   check_en = 0;
    int   cyc = 0;
    int   wr_cnt_a = 0, wr_cnt_b = 0, fd_cnt_b = 0;
    int   w0_times_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected bus words for one accepted record, straight from the word format
    task automatic model_push(input int p, input logic [9:0] idx, input logic [9:0] h,
                              input logic [14:0] c);
        exp_t e;
        int   hh;
        if (idx >= 640) begin
            if (p == 0) exp_err_a = 1; else exp_err_b = 1;
            return;
        end
        hh = (h > 480) ? 480 : int'(h);
        e.wd = 16'h8000 + 16'(idx); e.fd = 1'b0; e.pos = 2'd0;
        if (p == 0) q_a.push_back(e); else q_b.push_back(e);
        e.wd = 16'(hh); e.pos = 2'd1;
        if (p == 0) q_a.push_back(e); else q_b.push_back(e);
        e.wd = {1'b0, c}; e.fd = (idx == 639); e.pos = 2'd2;
        if (p == 0) q_a.push_back(e); else q_b.push_back(e);
    endtask

    task automatic port_check(input int p, input logic wr, input logic cs, input logic fd,
                              input logic [15:0] wd, input logic err);
        exp_t  e;
        bit    have;
        string tag;
        tag  = (p == 0) ? "a" : "b";
        have = (p == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
        e    = '0;
        if (have) e = (p == 0) ? q_a[0] : q_b[0];
        chk({tag, "_chipselect"}, 32'(cs), 32'(wr));
        chk({tag, "_err_col"}, 32'(err), (p == 0) ? 32'(exp_err_a) : 32'(exp_err_b));
        if (wr) begin
            if (!have) begin
                chk({tag, "_spurious_write"}, 32'(wr), 32'd0);
            end else begin
                chk({tag, "_writedata"}, 32'(wd), 32'(e.wd));
                chk({tag, "_frame_done"}, 32'(fd), 32'(e.fd));
                if (p == 0) begin
                    void'(q_a.pop_front());
                    wr_cnt_a++;
                end else begin
                    void'(q_b.pop_front());
                    wr_cnt_b++;
                    if (e.pos == 2'd0) w0_times_b.push_back(cyc);
                end
            end
            if (p == 1 && fd) fd_cnt_b++;
        end else begin
            chk({tag, "_frame_done_idle"}, 32'(fd), 32'd0);
            if (have && e.pos != 2'd0) chk({tag, "_burst_broken"}, 32'(wr), 32'd1);
        end
    endtask

    // Compare process: every cycle out of reset, both instances
    always @(negedge clk) begin
        if (reset_n && check_en) begin
            port_check(0, wr_a, cs_a, fd_a, wd_a, err_a);
            port_check(1, wr_b, cs_b, fd_b, wd_b, err_b);
        end
    end

    task automatic send(input int p, input logic [9:0] idx, input logic [9:0] h,
                        input logic [14:0] c);
        bit r;
        int n;
        n = 0;
        @(negedge clk);
        col_idx = idx; col_height = h; col_color = c;
        if (p == 0) valid_a = 1'b1; else valid_b = 1'b1;
        forever begin
            r = (p == 0) ? rdy_a : rdy_b;
            @(posedge clk);
            if (r || n >= 200) break;
            n++;
            @(negedge clk);
        end
        if (r) model_push(p, idx, h, c);
        else   chk("send_timeout", 32'(r), 32'd1);
    endtask

    task automatic drop();
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_write(input int p);
        bit w;
        w = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            w = (p == 0) ? wr_a : wr_b;
            if (w) break;
        end
        if (!w) chk("wait_write_timeout", 32'(w), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (q_a.size() == 0 && q_b.size() == 0) break;
        end
        chk("drain", 32'(q_a.size() + q_b.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        int seen;
        reset_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; vblank = 1'b0;
        col_idx = '0; col_height = '0; col_color = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_write", 32'(wr_a), 32'd0);
        chk("rst_writedata", 32'(wd_a), 32'd0);
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        reset_n = 1'b1;
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst_a", 32'(rdy_a), 32'd1);
        chk("ready_after_rst_b", 32'(rdy_b), 32'd1);

        // Single record: latency and literal words
        vblank = 1'b1;
        send(0, 10'd5, 10'd100, 15'h7C00);
        drop();
        chk("t2_lat_idle", 32'(wr_a), 32'd0);
        @(negedge clk);
        chk("t2_w0_wr", 32'(wr_a), 32'd1);
        chk("t2_w0", 32'(wd_a), 32'h8005);
        @(negedge clk);
        chk("t2_w1", 32'(wd_a), 32'h0064);
        @(negedge clk);
        chk("t2_w2", 32'(wd_a), 32'h7C00);
        @(negedge clk);
        chk("t2_end", 32'(wr_a), 32'd0);

        // Height clamp and invalid column
        send(0, 10'd10, 10'd600, 15'h1234);
        drop();
        wait_write(0);
        chk("t3_w0", 32'(wd_a), 32'h800A);
        @(negedge clk);
        chk("t3_clamp", 32'(wd_a), 32'h01E0);
        wait_drain();
        send(0, 10'd700, 10'd5, 15'h0001);
        drop();
        chk("t3_err_set", 32'(err_a), 32'd1);
        @(posedge clk);
        base = wr_cnt_a;
        repeat (6) @(posedge clk);
        chk("t3_no_write", 32'(wr_cnt_a - base), 32'd0);
        chk("t3_err_sticky", 32'(err_a), 32'd1);

        // Vblank gating: held, then nine back-to-back words
        @(negedge clk);
        vblank = 1'b0;
        send(0, 10'd1, 10'd10, 15'h0011);
        send(0, 10'd2, 10'd20, 15'h0022);
        send(0, 10'd3, 10'd30, 15'h0033);
        drop();
        @(posedge clk);
        base = wr_cnt_a;
        repeat (5) @(posedge clk);
        chk("t4_held", 32'(wr_cnt_a - base), 32'd0);
        @(negedge clk);
        vblank = 1'b1;
        wait_write(0);
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            chk("t4_back_to_back", 32'(wr_a), 32'd1);
        end
        @(negedge clk);
        chk("t4_after_nine", 32'(wr_a), 32'd0);

        // Vblank drops after word 4: record 2 completes, record 3 waits
        vblank = 1'b0;
        send(0, 10'd100, 10'd1, 15'h0101);
        send(0, 10'd101, 10'd2, 15'h0102);
        send(0, 10'd102, 10'd3, 15'h0103);
        drop();
        @(negedge clk);
        vblank = 1'b1;
        wait_write(0);
        seen = 1;
        while (seen < 4) begin
            @(negedge clk);
            if (wr_a) seen++;
        end
        vblank = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr_a) seen++;
        end
        chk("t4_partial_frame", 32'(seen), 32'd6);
        @(posedge clk);
        chk("t4_rec3_waiting", 32'(q_a.size()), 32'd3);
        @(negedge clk);
        vblank = 1'b1;
        wait_drain();

        // Backpressure: 8 fill the FIFO, then 2 more once it drains
        @(negedge clk);
        vblank = 1'b0;
        base = wr_cnt_a;
        for (int i = 0; i < 8; i++) begin
            send(0, 10'(200 + i), 10'(50 + i), 15'(16'h0200 + i));
        end
        @(negedge clk);
        chk("t5_full", 32'(rdy_a), 32'd0);
        vblank = 1'b1;
        send(0, 10'd208, 10'd58, 15'h0208);
        send(0, 10'd209, 10'd59, 15'h0209);
        drop();
        wait_drain();
        chk("t5_word_count", 32'(wr_cnt_a - base), 32'd30);

        // WRITE_GAP=2 instance: gap spacing and frame_done on idx 639
        w0_times_b.delete();
        send(1, 10'd638, 10'd200, 15'h03E0);
        send(1, 10'd639, 10'd480, 15'h001F);
        drop();
        wait_drain();
        chk("t6_bursts", 32'(w0_times_b.size()), 32'd2);
        if (w0_times_b.size() == 2)
            chk("t6_gap_spacing", 32'(w0_times_b[1] - w0_times_b[0]), 32'd5);
        chk("t6_frame_done_count", 32'(fd_cnt_b), 32'd1);

        // Reset mid-burst: outputs drop asynchronously
        send(0, 10'd30, 10'd40, 15'h00FF);
        drop();
        wait_write(0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_write_async", 32'(wr_a), 32'd0);
        chk("t1_cs_async", 32'(cs_a), 32'd0);
        chk("t1_ready_async", 32'(rdy_a), 32'd0);
        chk("t1_err_cleared", 32'(err_a), 32'd0);
        q_a.delete();
        q_b.delete();
        exp_err_a = 0;
        exp_err_b = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t1_ready_release", 32'(rdy_a), 32'd1);
        @(posedge clk);
        base = wr_cnt_a;
        repeat (5) @(posedge clk);
        chk("t1_quiet", 32'(wr_cnt_a - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
